// File: rtl/sw_pkg.sv
// Shared definitions for the switch request generator: channel geometry,
// the 96-bit point type and the sequencer FSM states.
package sw_pkg;

  localparam int unsigned CH_NUM = 8;
  localparam int unsigned CH_W   = 12;
  localparam int unsigned PT_W   = CH_NUM * CH_W;

  typedef logic [PT_W-1:0] point_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_REL,
    S_DWELL,
    S_DONE
  } state_t;

endpackage

// File: rtl/sw_pt_ram.sv
// Point table: DEPTH x W, one write port, registered read port.
// Read-first: a same-address write and read in one cycle returns the old word.
module sw_pt_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 96,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sw_req_gen.sv
// Plays a table of 8-channel DAC points to a switch controller over a
// four-phase req/ack handshake. Define SW_REQ_GEN_TIMEOUT_EN to add the ack-wait timeout.
module sw_req_gen
  import sw_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned CH_W    = 12,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tbl_we,
  input  logic [3:0]             tbl_addr,
  input  logic [CH_NUM*CH_W-1:0] tbl_wdata,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   loop_en,
  input  logic [4:0]             num_pts,
  input  logic [31:0]            reg_dwell,
  output logic [CH_NUM*CH_W-1:0] sw_val,
  output logic [7:0]             sw_req,
  input  logic                   sw_ack,
  output logic                   busy,
  output logic                   done,
  output logic [3:0]             cur_idx,
  output logic                   err
);

  localparam int unsigned W  = CH_NUM * CH_W;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0]  DEPTH_MAX = 5'(DEPTH);

  state_t      state, state_nxt;
  logic [3:0]  idx, idx_nxt;
  logic [4:0]  npts, npts_nxt;
  logic [31:0] dwell, dwell_nxt;
  logic [7:0]  req_nxt;
  logic        stop_lat, stop_nxt;
  logic        rd_en;

`ifdef SW_REQ_GEN_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tmo, tmo_nxt;
  logic          err_set, err_q;
`endif

  sw_pt_ram #(
    .DEPTH (DEPTH),
    .W     (W),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (tbl_we),
    .waddr (tbl_addr[AW-1:0]),
    .wdata (tbl_wdata),
    .re    (rd_en),
    .raddr (idx[AW-1:0]),
    .rdata (sw_val)
  );

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    npts_nxt  = npts;
    dwell_nxt = dwell;
    req_nxt   = sw_req;
    stop_nxt  = stop_lat;
    rd_en     = 1'b0;
    case (state)
      S_IDLE: begin
        stop_nxt = 1'b0;
        if (start) begin
          if (num_pts != 5'd0) begin
            idx_nxt   = '0;
            npts_nxt  = (num_pts > DEPTH_MAX) ? DEPTH_MAX : num_pts;
            state_nxt = S_LOAD;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      S_LOAD: begin
        if (stop) begin
          state_nxt = S_DONE;
        end else begin
          rd_en     = 1'b1;
          req_nxt   = '1;
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        stop_nxt = stop_lat | stop;
        if (sw_ack) begin
          req_nxt   = '0;
          state_nxt = S_REL;
        end
      end
      S_REL: begin
        stop_nxt = stop_lat | stop;
        if (!sw_ack) begin
          if (stop_lat || stop) begin
            state_nxt = S_DONE;
          end else begin
            dwell_nxt = reg_dwell;
            state_nxt = S_DWELL;
          end
        end
      end
      S_DWELL: begin
        if (stop) begin
          state_nxt = S_DONE;
        end else if (dwell == 32'd0) begin
          if ({1'b0, idx} + 5'd1 < npts) begin
            idx_nxt   = idx + 4'd1;
            state_nxt = S_LOAD;
          end else if (loop_en) begin
            idx_nxt   = '0;
            state_nxt = S_LOAD;
          end else begin
            state_nxt = S_DONE;
          end
        end else begin
          dwell_nxt = dwell - 32'd1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

`ifdef SW_REQ_GEN_TIMEOUT_EN
    // One counter spans REQ and REL; expiry overrides whatever the case chose.
    err_set = 1'b0;
    tmo_nxt = '0;
    if (state == S_REQ || state == S_REL) begin
      if (tmo == TMO_LAST) begin
        err_set   = 1'b1;
        req_nxt   = '0;
        state_nxt = S_DONE;
      end else begin
        tmo_nxt = tmo + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      npts     <= '0;
      dwell    <= '0;
      sw_req   <= '0;
      stop_lat <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      npts     <= npts_nxt;
      dwell    <= dwell_nxt;
      sw_req   <= req_nxt;
      stop_lat <= stop_nxt;
      done     <= (state == S_DONE);
    end
  end

`ifdef SW_REQ_GEN_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo   <= '0;
      err_q <= 1'b0;
    end else begin
      tmo <= tmo_nxt;
      if (state == S_IDLE && start) err_q <= 1'b0;
      else if (err_set)             err_q <= 1'b1;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy    = (state != S_IDLE);
  assign cur_idx = idx;

endmodule

// File: tb/tb_sw_req_gen.sv
// Randomized bench for sw_req_gen: an ack responder drives the handshake and a
// monitor records every request against a table-and-index reference model.
module tb_sw_req_gen;
  import sw_pkg::*;

  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst, tbl_we, start, stop, loop_en, sw_ack, busy, done, err;
  logic [3:0]  tbl_addr, cur_idx;
  logic [4:0]  num_pts;
  logic [31:0] reg_dwell;
  logic [7:0]  sw_req;
  point_t      tbl_wdata, sw_val;

  sw_req_gen #(.DEPTH(16), .CH_W(12), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
    .start(start), .stop(stop), .loop_en(loop_en), .num_pts(num_pts), .reg_dwell(reg_dwell),
    .sw_val(sw_val), .sw_req(sw_req), .sw_ack(sw_ack), .busy(busy), .done(done),
    .cur_idx(cur_idx), .err(err)
  );

  always #5 clk = ~clk;

  int          checks = 0, errors = 0;
  point_t      model [DEPTH];
  int unsigned ack_delay = 2, wait_cnt = 0, cur_dwell = 0;
  bit          ack_hold = 0, have_last = 0;
  int          cycle = 0, last_rise = 0, rises = 0, done_cnt = 0;
  logic [3:0]  idx_q [$];
  point_t      val_q [$];
  logic [7:0]  prev_req = '0;

  // Four-phase responder: ack ack_delay cycles after req, release after req drops.
  initial begin
    sw_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sw_ack = 1'b0; wait_cnt = 0;
      end else if (!sw_ack && sw_req == 8'hFF && !ack_hold) begin
        if (wait_cnt >= ack_delay) begin sw_ack = 1'b1; wait_cnt = 0; end
        else wait_cnt++;
      end else if (sw_ack && sw_req == 8'h00) begin
        sw_ack = 1'b0;
      end else if (sw_req != 8'hFF) begin
        wait_cnt = 0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    cycle++;
    if (rst) begin
      prev_req = '0;
    end else begin
      checks++;
      if (sw_req !== 8'h00 && sw_req !== 8'hFF) begin
        errors++; $display("FAIL req_level: sw_req=%h required 00 or ff", sw_req);
      end
      if (prev_req == 8'h00 && sw_req == 8'hFF) begin
        rises++;
        idx_q.push_back(cur_idx);
        val_q.push_back(sw_val);
        checks++;
        if (sw_ack !== 1'b0) begin
          errors++; $display("FAIL req_rise_ack: sw_ack=%b required 0", sw_ack);
        end
        if (have_last) begin
          checks++;
          if (cycle - last_rise < int'(cur_dwell) + 4) begin
            errors++; $display("FAIL req_spacing: %0d cycles required >= %0d", cycle - last_rise, cur_dwell + 4);
          end
        end
        last_rise = cycle; have_last = 1;
      end
      if (prev_req == 8'hFF && sw_req == 8'h00 && err !== 1'b1) begin
        checks++;
        if (sw_ack !== 1'b1) begin
          errors++; $display("FAIL req_fall_ack: sw_ack=%b required 1", sw_ack);
        end
      end
      if (done === 1'b1) begin
        done_cnt++; checks++;
        if (busy !== 1'b0) begin
          errors++; $display("FAIL done_busy: busy=%b required 0", busy);
        end
      end
      prev_req = sw_req;
    end
  end

  task automatic write_pt(input int unsigned a, input point_t d);
    @(negedge clk);
    tbl_we = 1'b1; tbl_addr = 4'(a); tbl_wdata = d; model[a] = d;
    @(negedge clk);
    tbl_we = 1'b0;
  endtask

  function automatic point_t rand_pt();
    point_t p;
    p = {$urandom(), $urandom(), $urandom()};
    return p;
  endfunction

  task automatic start_run(input int unsigned n, input int unsigned dw, input bit lp);
    @(negedge clk);
    idx_q.delete(); val_q.delete();
    rises = 0; done_cnt = 0; have_last = 0; cur_dwell = dw;
    num_pts = 5'(n); reg_dwell = dw; loop_en = lp; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt > 0) begin ok = 1; break; end
    end
  endtask

  task automatic wait_req(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sw_req == 8'hFF) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({sw_val, sw_req, busy, done, cur_idx, err} !== '0) begin
      errors++; $display("FAIL reset_state: req=%h busy=%b done=%b idx=%0d err=%b required all 0", sw_req, busy, done, cur_idx, err);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    bit ok;
    for (int unsigned a = 0; a < DEPTH; a++) write_pt(a, rand_pt());
    for (int unsigned k = 0; k < 3; k++) write_pt(k, {8{12'(k + 1)}});
    ack_delay = 2;
    start_run(3, 10, 0);
    wait_done(600, ok);
    repeat (5) @(negedge clk);
    checks++;
    if (!ok || rises != 3 || done_cnt != 1) begin
      errors++; $display("FAIL basic_count: done=%0b reqs=%0d dones=%0d required 1/3/1", ok, rises, done_cnt);
    end
    for (int k = 0; k < idx_q.size(); k++) begin
      checks++;
      if (idx_q[k] !== 4'(k) || val_q[k] !== model[k]) begin
        errors++; $display("FAIL basic_point%0d: idx=%0d val=%h required idx=%0d val=%h", k, idx_q[k], val_q[k], k, model[k]);
      end
    end
    checks++;
    if (sw_val !== model[2] || busy !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL basic_hold: val=%h busy=%b err=%b required %h/0/0", sw_val, busy, err, model[2]);
    end
  endtask

  task automatic test_loop();
    bit ok = 0;
    int unsigned dw = $urandom_range(3, 8);
    ack_delay = $urandom_range(0, 3);
    start_run(2, dw, 1);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (rises >= 5 && sw_req == 8'h00) begin ok = 1; break; end
    end
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    checks++;
    if (!ok || done !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL loop_stop_state: reached=%0b done=%b busy=%b required 1/0/1", ok, done, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL loop_done: done=%b required 1", done);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (rises != 5 || done_cnt != 1) begin
      errors++; $display("FAIL loop_count: reqs=%0d dones=%0d required 5/1", rises, done_cnt);
    end
    for (int k = 0; k < idx_q.size(); k++) begin
      checks++;
      if (idx_q[k] !== 4'(k % 2) || val_q[k] !== model[k % 2]) begin
        errors++; $display("FAIL loop_point%0d: idx=%0d required %0d", k, idx_q[k], k % 2);
      end
    end
  endtask

  task automatic test_stop_req();
    bit ok, held = 1;
    ack_delay = 20;
    start_run(3, 5, 0);
    wait_req(50, ok);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (sw_req !== 8'hFF) held = 0;
      @(negedge clk);
    end
    checks++;
    if (!ok || !held) begin
      errors++; $display("FAIL stop_req_hold: seen=%0b held=%0b required 1/1", ok, held);
    end
    wait_done(200, ok);
    repeat (30) @(negedge clk);
    checks++;
    if (!ok || rises != 1 || done_cnt != 1 || busy !== 1'b0) begin
      errors++; $display("FAIL stop_req_end: done=%0b reqs=%0d dones=%0d busy=%b required 1/1/1/0", ok, rises, done_cnt, busy);
    end
  endtask

  task automatic test_zero_pts();
    start_run(0, 4, 0);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL zero_first: done=%b busy=%b required 0/1", done, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_done: done=%b busy=%b required 1/0", done, busy);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (rises != 0 || done_cnt != 1) begin
      errors++; $display("FAIL zero_count: reqs=%0d dones=%0d required 0/1", rises, done_cnt);
    end
  endtask

  // Randomized runs; n = 20 is always included to exercise the DEPTH clamp.
  task automatic test_random();
    bit ok;
    for (int r = 0; r < 5; r++) begin
      int unsigned n   = (r == 0) ? 20 : $urandom_range(1, 20);
      int unsigned dw  = $urandom_range(0, 6);
      int unsigned exp = (n > DEPTH) ? DEPTH : n;
      for (int unsigned a = 0; a < DEPTH; a++) write_pt(a, rand_pt());
      ack_delay = $urandom_range(0, 4);
      start_run(n, dw, 0);
      wait_done(3000, ok);
      checks++;
      if (!ok || rises != int'(exp)) begin
        errors++; $display("FAIL rand%0d_count: done=%0b reqs=%0d required 1/%0d", r, ok, rises, exp);
      end
      for (int k = 0; k < idx_q.size(); k++) begin
        checks++;
        if (idx_q[k] !== 4'(k) || val_q[k] !== model[k]) begin
          errors++; $display("FAIL rand%0d_point%0d: idx=%0d val=%h required idx=%0d val=%h", r, k, idx_q[k], val_q[k], k, model[k]);
        end
      end
      checks++;
      if (sw_val !== model[exp - 1]) begin
        errors++; $display("FAIL rand%0d_hold: val=%h required %h", r, sw_val, model[exp - 1]);
      end
    end
  endtask

  task automatic test_table_write();
    bit ok;
    point_t old0 = model[0], new0 = rand_pt(), new1 = rand_pt();
    ack_delay = 1;
    // Write entry 0 in the cycle the first LOAD reads it: old data expected.
    @(negedge clk);
    idx_q.delete(); val_q.delete(); rises = 0; done_cnt = 0; have_last = 0; cur_dwell = 30;
    num_pts = 5'd2; reg_dwell = 30; loop_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; tbl_we = 1'b1; tbl_addr = 4'd0; tbl_wdata = new0;
    @(negedge clk);
    tbl_we = 1'b0; model[0] = new0;
    wait_req(20, ok);
    write_pt(1, new1);
    wait_done(500, ok);
    checks++;
    if (!ok || rises != 2) begin
      errors++; $display("FAIL twr_count: done=%0b reqs=%0d required 1/2", ok, rises);
    end else begin
      checks++;
      if (val_q[0] !== old0 || val_q[1] !== new1) begin
        errors++; $display("FAIL twr_data: v0=%h v1=%h required %h %h", val_q[0], val_q[1], old0, new1);
      end
    end
    start_run(1, 0, 0);
    wait_done(200, ok);
    checks++;
    if (!ok || val_q.size() != 1 || sw_val !== new0) begin
      errors++; $display("FAIL twr_new: val=%h required %h", sw_val, new0);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    ack_delay = 10;
    start_run(3, 2, 0);
    wait_req(50, ok);
    rst = 1'b1;
    #1;
    checks++;
    if (!ok || {sw_val, sw_req, busy, done, cur_idx, err} !== '0) begin
      errors++; $display("FAIL rst_mid: seen=%0b req=%h busy=%b idx=%0d required 1/00/0/0", ok, sw_req, busy, cur_idx);
    end
    @(negedge clk); rst = 1'b0;
    write_pt(0, rand_pt());
    write_pt(1, rand_pt());
    ack_delay = 1;
    start_run(2, 3, 0);
    wait_done(300, ok);
    checks++;
    if (!ok || rises != 2) begin
      errors++; $display("FAIL rst_after_count: done=%0b reqs=%0d required 1/2", ok, rises);
    end else begin
      checks++;
      if (idx_q[0] !== 4'd0 || idx_q[1] !== 4'd1 || val_q[0] !== model[0] || val_q[1] !== model[1]) begin
        errors++; $display("FAIL rst_after_seq: idx=%0d,%0d required 0,1", idx_q[0], idx_q[1]);
      end
    end
  endtask

`ifdef SW_REQ_GEN_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    ack_hold = 1;
    start_run(2, 3, 0);
    wait_req(20, ok);
    repeat (63) @(negedge clk);
    checks++;
    if (!ok || err !== 1'b0 || sw_req !== 8'hFF) begin
      errors++; $display("FAIL tmo_before: err=%b req=%h required 0/ff", err, sw_req);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || sw_req !== 8'h00) begin
      errors++; $display("FAIL tmo_fire: err=%b req=%h required 1/00", err, sw_req);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL tmo_done: done=%b required 1", done);
    end
    ack_hold = 0;
    start_run(1, 2, 0);
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL tmo_clear: err=%b required 0", err);
    end
    wait_done(200, ok);
  endtask
`endif

  initial begin
    rst = 1'b1; tbl_we = 1'b0; tbl_addr = '0; tbl_wdata = '0;
    start = 1'b0; stop = 1'b0; loop_en = 1'b0; num_pts = '0; reg_dwell = '0;
    test_reset();
    test_basic();
    test_loop();
    test_stop_req();
    test_zero_pts();
    test_random();
    test_table_write();
    test_reset_mid();
`ifdef SW_REQ_GEN_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
